// File: rtl/pwm_timer_pkg.sv
// pwm_timer_pkg: shared definitions for the PWM timer.
//   ADDR_*  : register-file addresses for the write port
//   state_e : controller states
package pwm_timer_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_REPEAT = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_timer_if.sv
// pwm_timer_if: register write port, start request and PWM outputs.
//   i_start     : one-cycle start request
//   i_we        : register write enable
//   i_addr      : register select (0 PERIOD, 1 DUTY, 2 REPEAT, 3 reserved)
//   i_wdata     : write data
//   o_pwm       : PWM waveform
//   o_timer_end : one-cycle completion pulse
// master drives the requests, slave (the timer) drives the outputs.
interface pwm_timer_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic             i_we;
  logic [1:0]       i_addr;
  logic [WIDTH-1:0] i_wdata;
  logic             o_pwm;
  logic             o_timer_end;

  modport master (
    output i_start, i_we, i_addr, i_wdata,
    input  o_pwm, o_timer_end
  );

  modport slave (
    input  i_start, i_we, i_addr, i_wdata,
    output o_pwm, o_timer_end
  );
endinterface

// File: rtl/pwm_timer_regs.sv
// pwm_timer_regs: write-only configuration registers.
//   i_clk, i_rst         : clock, async active-high reset
//   i_we, i_addr, i_wdata: write port; address 3 is ignored
//   o_period, o_duty, o_repeat : current register contents
module pwm_timer_regs
  import pwm_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_duty,
  output logic [WIDTH-1:0] o_repeat
);

  logic we_period;
  logic we_duty;
  logic we_repeat;

  always_comb begin
    we_period = i_we && (i_addr == ADDR_PERIOD);
    we_duty   = i_we && (i_addr == ADDR_DUTY);
    we_repeat = i_we && (i_addr == ADDR_REPEAT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_period <= '0;
      o_duty   <= '0;
      o_repeat <= '0;
    end else begin
      if (we_period) o_period <= i_wdata;
      if (we_duty)   o_duty   <= i_wdata;
      if (we_repeat) o_repeat <= i_wdata;
    end
  end

endmodule

// File: rtl/pwm_timer.sv
// pwm_timer: emits REPEAT periods of a PERIOD/DUTY PWM waveform after a
// start pulse, then a one-cycle o_timer_end pulse.
//   i_clk : clock
//   i_rst : async active-high reset
//   bus   : pwm_timer_if slave (start, register writes, o_pwm, o_timer_end)
//
// state | meaning
// IDLE  | waiting for i_start, o_pwm low
// RUN   | counting cnt within a period and rep across periods
module pwm_timer
  import pwm_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pwm_timer_if.slave  bus
);

  logic [WIDTH-1:0] period_q, duty_q, repeat_q;
  logic [WIDTH-1:0] period_sh, duty_sh, repeat_sh;
  logic [WIDTH-1:0] cnt, rep;
  logic [WIDTH-1:0] cnt_inc, rep_inc;
  state_e           state;
  logic             pwm_q;
  logic             end_q;

  pwm_timer_regs #(.WIDTH(WIDTH)) u_regs (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (bus.i_we),
    .i_addr   (bus.i_addr),
    .i_wdata  (bus.i_wdata),
    .o_period (period_q),
    .o_duty   (duty_q),
    .o_repeat (repeat_q)
  );

  // cnt stays below period_sh and rep below repeat_sh, so neither increment wraps.
  assign cnt_inc = cnt + 1'b1;
  assign rep_inc = rep + 1'b1;

  // o_pwm is registered: each edge computes the level for the value cnt
  // takes on that same edge, so the output lines up with the counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      period_sh <= '0;
      duty_sh   <= '0;
      repeat_sh <= '0;
      cnt       <= '0;
      rep       <= '0;
      pwm_q     <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      end_q <= 1'b0;
      case (state)
        IDLE: begin
          pwm_q <= 1'b0;
          if (bus.i_start) begin
            period_sh <= period_q;
            duty_sh   <= duty_q;
            repeat_sh <= repeat_q;
            cnt       <= '0;
            rep       <= '0;
            if (period_q == '0 || repeat_q == '0) begin
              end_q <= 1'b1;
            end else begin
              state <= RUN;
              pwm_q <= (duty_q != '0);
            end
          end
        end
        RUN: begin
          if (cnt == period_sh - 1'b1) begin
            cnt <= '0;
            if (rep_inc == repeat_sh) begin
              state <= IDLE;
              end_q <= 1'b1;
              pwm_q <= 1'b0;
            end else begin
              rep   <= rep_inc;
              pwm_q <= (duty_sh != '0);
            end
          end else begin
            cnt   <= cnt_inc;
            pwm_q <= (cnt_inc < duty_sh);
          end
        end
        default: begin
          state <= IDLE;
          pwm_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pwm       = pwm_q;
  assign bus.o_timer_end = end_q;

endmodule

// File: tb/tb_pwm_timer.sv
module tb_pwm_timer;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  pwm_timer_if #(.WIDTH(16)) bus ();

  pwm_timer #(.WIDTH(16)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Behavioural model: a run is a span of PERIOD*REPEAT cycles after the
  // start edge; within it the waveform is high when the position inside the
  // current period is below DUTY. The end pulse is the cycle after the span.
  longint m_reg [0:2];
  longint m_p, m_d, m_r, m_el;
  bit     m_active;
  logic   e_pwm, e_end;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 3; k++) m_reg[k] = 0;
      m_active = 0;
      m_el = 0;
      e_pwm = 1'b0;
      e_end = 1'b0;
    end else begin
      e_pwm = 1'b0;
      e_end = 1'b0;
      if (m_active) begin
        m_el++;
        if (m_el > m_p * m_r) begin
          m_active = 0;
          e_end = 1'b1;
        end else begin
          e_pwm = (((m_el - 1) % m_p) < m_d);
        end
      end else if (bus.i_start) begin
        m_p = m_reg[0];
        m_d = m_reg[1];
        m_r = m_reg[2];
        if (m_p == 0 || m_r == 0) begin
          e_end = 1'b1;
        end else begin
          m_active = 1;
          m_el = 1;
          e_pwm = (m_d > 0);
        end
      end
      if (bus.i_we && bus.i_addr != 2'd3) m_reg[bus.i_addr] = longint'(bus.i_wdata);
    end
  end

  initial begin
    e_pwm = 1'b0;
    e_end = 1'b0;
  end

  always @(negedge i_clk) begin
    check_bit("pwm_vs_model", bus.o_pwm, e_pwm);
    check_bit("end_vs_model", bus.o_timer_end, e_end);
  end

  task automatic next_cycle();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.i_we    = 1'b1;
    bus.i_addr  = a;
    bus.i_wdata = d;
    next_cycle();
    bus.i_we    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    next_cycle();
    bus.i_start = 1'b0;
  endtask

  // Observes n cycles starting with the current one (cycle 1 right after a
  // pulse_start). Optionally injects a start or a write at a given cycle.
  task automatic measure(input int n, input int start_at, input int wr_at,
                         input logic [1:0] wa, input logic [15:0] wd,
                         output int highs, output int end_idx, output int ends);
    highs = 0;
    end_idx = -1;
    ends = 0;
    for (int i = 1; i <= n; i++) begin
      if (bus.o_pwm) highs++;
      if (bus.o_timer_end) begin
        ends++;
        if (end_idx < 0) end_idx = i;
      end
      bus.i_start = (i == start_at);
      bus.i_we    = (i == wr_at);
      bus.i_addr  = wa;
      bus.i_wdata = wd;
      next_cycle();
    end
    bus.i_start = 1'b0;
    bus.i_we    = 1'b0;
  endtask

  int hi, ei, ne;

  initial begin
    bus.i_start = 1'b0;
    bus.i_we    = 1'b0;
    bus.i_addr  = 2'd0;
    bus.i_wdata = '0;
    #1 i_rst = 1'b1;
    repeat (3) next_cycle();
    check_bit("reset_pwm", bus.o_pwm, 1'b0);
    check_bit("reset_end", bus.o_timer_end, 1'b0);
    i_rst = 1'b0;
    next_cycle();

    // 20/10 x2, stray start at cycle 30, DUTY=5 written at cycle 15
    wr(2'd0, 16'd20); wr(2'd1, 16'd10); wr(2'd2, 16'd2);
    pulse_start();
    check_bit("first_cycle_high", bus.o_pwm, 1'b1);
    measure(45, 30, 15, 2'd1, 16'd5, hi, ei, ne);
    check_int("run1_highs", hi, 20);
    check_int("run1_end_cycle", ei, 41);
    check_int("run1_end_count", ne, 1);

    repeat (5) next_cycle();
    pulse_start();
    measure(45, 0, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("run2_highs", hi, 10);
    check_int("run2_end_cycle", ei, 41);

    repeat (5) next_cycle();
    pulse_start();
    measure(45, 0, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("run3_highs", hi, 10);
    check_int("run3_end_cycle", ei, 41);

    // degenerate configurations
    wr(2'd0, 16'd4); wr(2'd1, 16'd4); wr(2'd2, 16'd2);
    pulse_start();
    measure(10, 0, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("duty_eq_period_highs", hi, 8);
    check_int("duty_eq_period_end", ei, 9);
    wr(2'd1, 16'd0);
    pulse_start();
    measure(10, 0, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("duty0_highs", hi, 0);
    check_int("duty0_end", ei, 9);
    wr(2'd2, 16'd0);
    pulse_start();
    measure(5, 0, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("repeat0_highs", hi, 0);
    check_int("repeat0_end", ei, 1);

    // reserved address write leaves PERIOD=4, DUTY=2, REPEAT=3 intact
    wr(2'd2, 16'd3); wr(2'd1, 16'd2); wr(2'd3, 16'hFFFF);
    pulse_start();
    measure(15, 0, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("addr3_highs", hi, 6);
    check_int("addr3_end", ei, 13);

    // start accepted in the end-pulse cycle
    wr(2'd0, 16'd3); wr(2'd1, 16'd1); wr(2'd2, 16'd1);
    pulse_start();
    measure(10, 4, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("back2back_highs", hi, 2);
    check_int("back2back_ends", ne, 2);

    // reset mid-run
    wr(2'd0, 16'd20); wr(2'd1, 16'd20); wr(2'd2, 16'd5);
    pulse_start();
    repeat (5) next_cycle();
    check_bit("prereset_pwm", bus.o_pwm, 1'b1);
    i_rst = 1'b1;
    #1;
    check_bit("midreset_pwm", bus.o_pwm, 1'b0);
    check_bit("midreset_end", bus.o_timer_end, 1'b0);
    next_cycle();
    i_rst = 1'b0;
    next_cycle();
    pulse_start();
    measure(5, 0, 0, 2'd0, 16'd0, hi, ei, ne);
    check_int("postreset_highs", hi, 0);
    check_int("postreset_end", ei, 1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.i_start = ($urandom_range(0, 5) == 0);
      bus.i_we    = ($urandom_range(0, 3) == 0);
      bus.i_addr  = 2'($urandom_range(0, 3));
      case (bus.i_addr)
        2'd0:    bus.i_wdata = 16'($urandom_range(0, 8));
        2'd1:    bus.i_wdata = 16'($urandom_range(0, 10));
        2'd2:    bus.i_wdata = 16'($urandom_range(0, 3));
        default: bus.i_wdata = 16'($urandom);
      endcase
      next_cycle();
    end
    bus.i_start = 1'b0;
    bus.i_we    = 1'b0;
    repeat (40) next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
